// File: rtl/register_bus_reader.sv
// Sequential reader for the switchable-register bank: streams one register, or a wrap-around
// burst of consecutive registers, onto a registered A-bus under a valid/ready handshake.
module register_bus_reader #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREG  = 8,
   parameter int unsigned AW    = 3
) (
   input  logic                     CLK,
   input  logic                     CLR,
   input  logic [NREG*WIDTH-1:0]    R_in,
   input  logic                     req,
   input  logic [AW-1:0]            start_addr,
   input  logic [AW:0]              count,
   output logic [WIDTH-1:0]         A_bus,
   output logic                     A_valid,
   input  logic                     A_ready,
   output logic                     busy,
   output logic                     done,
   output logic [AW-1:0]            cur_addr
);

   typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

   state_e           r_state;
   logic [AW-1:0]    r_cur_addr;
   logic [AW:0]      r_remaining;
   logic [WIDTH-1:0] r_a_bus;
   logic             r_a_valid;
   logic             r_done;

   logic [WIDTH-1:0] w_words [NREG];
   logic [AW-1:0]    w_next_addr;

   always_comb begin
      for (int k = 0; k < NREG; k++) begin
         w_words[k] = R_in[k*WIDTH +: WIDTH];
      end
   end

   // AW-bit addition wraps NREG-1 back to 0 for free
   assign w_next_addr = r_cur_addr + AW'(1);

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_state     <= StIdle;
         r_cur_addr  <= '0;
         r_remaining <= '0;
         r_a_bus     <= '0;
         r_a_valid   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (req) begin
                  r_cur_addr  <= start_addr;
                  r_remaining <= (count == '0) ? (AW+1)'(NREG) : count;
                  r_state     <= StLoad;
               end
            end
            StLoad: begin
               r_a_bus   <= w_words[r_cur_addr];
               r_a_valid <= 1'b1;
               r_state   <= StSend;
            end
            StSend: begin
               if (r_a_valid && A_ready) begin
                  r_remaining <= r_remaining - (AW+1)'(1);
                  if (r_remaining > (AW+1)'(1)) begin
                     r_cur_addr <= w_next_addr;
                     r_a_bus    <= w_words[w_next_addr];
                  end else begin
                     r_a_valid <= 1'b0;
                     r_done    <= 1'b1;
                     r_state   <= StIdle;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign A_bus    = r_a_bus;
   assign A_valid  = r_a_valid;
   assign busy     = (r_state != StIdle);
   assign done     = r_done;
   assign cur_addr = r_cur_addr;

endmodule

// File: tb/tb_register_bus_reader.sv
// Randomized scoreboard bench for register_bus_reader: expected words are queued at request
// time from a plain register-array model and popped by a monitor on every handshake.
module tb_register_bus_reader;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NREG  = 8;
   localparam int unsigned AW    = 3;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [AW-1:0]    addr;
   } exp_t;

   logic                  CLK;
   logic                  CLR;
   logic [NREG*WIDTH-1:0] R_in;
   logic                  req;
   logic [AW-1:0]         start_addr;
   logic [AW:0]           count;
   logic [WIDTH-1:0]      A_bus;
   logic                  A_valid;
   logic                  A_ready;
   logic                  busy;
   logic                  done;
   logic [AW-1:0]         cur_addr;

   logic [WIDTH-1:0] regs [NREG];
   exp_t             sb_q [$];
   int               n_checks = 0;
   int               n_pass   = 0;
   int               done_seen = 0;

   register_bus_reader #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
      .CLK        (CLK),
      .CLR        (CLR),
      .R_in       (R_in),
      .req        (req),
      .start_addr (start_addr),
      .count      (count),
      .A_bus      (A_bus),
      .A_valid    (A_valid),
      .A_ready    (A_ready),
      .busy       (busy),
      .done       (done),
      .cur_addr   (cur_addr)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always_comb begin
      for (int k = 0; k < NREG; k++) R_in[k*WIDTH +: WIDTH] = regs[k];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: a word is consumed at the edge following a negedge where valid & ready
   always @(negedge CLK) begin
      if (CLR && A_valid && A_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got %0h, expected no transfer at %0t", A_bus, $time);
         end else begin
            check("a_bus", A_bus, sb_q[0].data);
            check("cur_addr", cur_addr, sb_q[0].addr);
            void'(sb_q.pop_front());
         end
      end
      if (done) begin
         done_seen++;
         check("busy_in_done", busy, 0);
      end
   end

   task automatic push_expected(input int start, input int n);
      for (int k = 0; k < n; k++) begin
         exp_t e;
         e.addr = AW'((start + k) % NREG);
         e.data = regs[(start + k) % NREG];
         sb_q.push_back(e);
      end
   endtask

   // Wait for busy to drop (we end up in the done cycle), then verify completion
   task automatic finish_burst(input int d0, input int rmode, input bit noise, output int cyc);
      cyc = 0;
      while (busy && cyc < 1000) begin
         A_ready = (rmode == 0) ? 1'b1 : 1'(($urandom_range(0, 3) != 0));
         if (noise && sb_q.size() > 0) begin
            req        = 1'($urandom_range(0, 1));
            start_addr = AW'($urandom);
            count      = (AW+1)'($urandom);
         end
         @(posedge CLK); #1;
         cyc++;
      end
      req = 1'b0;
      A_ready = 1'b0;
      check("burst_timeout", (cyc < 1000), 1);
      @(negedge CLK); #1;
      check("done_pulses", done_seen - d0, 1);
      check("queue_empty", sb_q.size(), 0);
   endtask

   task automatic burst(input int start, input int cnt, input int rmode, input bit noise);
      int n;
      int d0;
      int cyc;
      n  = (cnt == 0) ? NREG : cnt;
      d0 = done_seen;
      push_expected(start, n);
      req = 1'b1; start_addr = AW'(start); count = (AW+1)'(cnt);
      A_ready = (rmode == 0);
      @(posedge CLK); #1;
      req = 1'b0; start_addr = AW'($urandom); count = (AW+1)'($urandom);
      check("load_busy", busy, 1);
      check("load_valid", A_valid, 0);
      @(posedge CLK); #1;
      check("first_valid", A_valid, 1);
      check("first_addr", cur_addr, start);
      finish_burst(d0, rmode, noise, cyc);
      if (rmode == 0) check("throughput", cyc, n);
   endtask

   initial begin
      int d0;
      int cyc;
      req = 0; start_addr = 0; count = 0; A_ready = 0;
      for (int k = 0; k < NREG; k++) regs[k] = WIDTH'($urandom);
      CLR = 1'b1;
      #1 CLR = 1'b0;
      #2;
      check("rst_valid", A_valid, 0);
      check("rst_bus", A_bus, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_addr", cur_addr, 0);
      @(negedge CLK) CLR = 1'b1;

      // Mid-cycle reset with a burst stalled on the bus
      @(posedge CLK); #1;
      req = 1; start_addr = 5; count = 3; A_ready = 0;
      @(posedge CLK); #1;
      req = 0;
      repeat (2) @(posedge CLK);
      #3 CLR = 1'b0;
      #1;
      check("midrst_valid", A_valid, 0);
      check("midrst_bus", A_bus, 0);
      check("midrst_busy", busy, 0);
      check("midrst_addr", cur_addr, 0);
      @(negedge CLK) CLR = 1'b1;

      // Single read
      regs[3] = 16'hA5A5;
      burst(3, 1, 0, 0);

      // Wrapping burst
      for (int k = 0; k < NREG; k++) regs[k] = 16'h1000 + WIDTH'(k);
      burst(6, 4, 0, 0);

      // Backpressure with snapshot
      regs[2] = 16'h1111; regs[3] = 16'h3333;
      d0 = done_seen;
      push_expected(2, 2);
      req = 1; start_addr = 2; count = 2; A_ready = 0;
      @(posedge CLK); #1;
      req = 0;
      @(posedge CLK); #1;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) regs[2] = 16'h2222;
         @(posedge CLK); #1;
         check("stall_bus", A_bus, 16'h1111);
         check("stall_valid", A_valid, 1);
         check("stall_addr", cur_addr, 2);
      end
      A_ready = 1;
      finish_burst(d0, 0, 0, cyc);

      // Full-bank burst with req noise while busy
      for (int k = 0; k < NREG; k++) regs[k] = WIDTH'($urandom);
      burst(0, 0, 0, 1);

      // Randomized bursts with random backpressure and ignored requests
      for (int t = 0; t < 20; t++) begin
         for (int k = 0; k < NREG; k++) regs[k] = WIDTH'($urandom);
         burst(int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG)), 1, 1);
      end

      // Reset after the 2nd word of a 5-word burst
      for (int k = 0; k < NREG; k++) regs[k] = WIDTH'($urandom);
      push_expected(5, 5);
      req = 1; start_addr = 5; count = 5; A_ready = 1;
      @(posedge CLK); #1;
      req = 0;
      cyc = 0;
      while (sb_q.size() > 3 && cyc < 50) begin
         @(posedge CLK); #1;
         cyc++;
      end
      check("abort_timeout", (cyc < 50), 1);
      CLR = 1'b0;
      A_ready = 0;
      #1;
      sb_q.delete();
      d0 = done_seen;
      check("abort_valid", A_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_addr", cur_addr, 0);
      repeat (2) @(posedge CLK);
      @(negedge CLK) CLR = 1'b1;
      #1;
      check("abort_no_done", done_seen - d0, 0);
      burst(4, 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
